// File: rtl/id_decode_stage.sv
// id_decode_stage: registered RV32I decode stage (ID -> EX).
// Decodes the fetched instruction into the EX control bundle and registers it
// together with PC/IR and a valid bit. It also handles downstream stall, branch
// flush, load-use bubbles, an optional illegal-instruction halt, optional RV32M
// decode and a debug issue counter.
module id_decode_stage #(
    parameter int XLEN      = 32,
    parameter int EN_MUL    = 0,
    parameter int TRAP_HOLD = 1,
    parameter int CNT_W     = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_if_valid,
    input  logic [31:0]                     i_if_ir,
    input  logic [XLEN-1:0]                 i_if_pc,
    input  logic                            i_ex_stall,
    input  logic                            i_flush,
    output logic                            o_id_ready,
    output logic                            o_id_ex_valid,
    output logic [XLEN-1:0]                 o_id_ex_pc,
    output logic [31:0]                     o_id_ex_ir,
    output logic [((EN_MUL != 0) ? 5 : 4)-1:0] o_id_ex_alu_fun,
    output logic                            o_id_ex_alu_srca,
    output logic [1:0]                      o_id_ex_alu_srcb,
    output logic [1:0]                      o_id_ex_rf_wr_sel,
    output logic                            o_id_ex_reg_write,
    output logic                            o_id_ex_mem_write,
    output logic                            o_id_ex_mem_read2,
    output logic                            o_id_ex_branch,
    output logic                            o_id_ex_jump,
    output logic                            o_id_ex_illegal,
    output logic                            o_halted,
    output logic [CNT_W-1:0]                o_issue_cnt
);

    localparam int AFW = (EN_MUL != 0) ? 5 : 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Control bundle carried into EX; alu_fun is always held 5 bits wide
    // internally and trimmed at the port when RV32M is not decoded.
    typedef struct packed {
        logic [4:0] alu_fun;
        logic       alu_srca;
        logic [1:0] alu_srcb;
        logic [1:0] rf_wr_sel;
        logic       reg_write;
        logic       mem_write;
        logic       mem_read2;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    ctrl_t           r_ctrl;
    ctrl_t           w_dec;
    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [CNT_W-1:0] r_cnt;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_ex_rd;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_hazard;
    logic       w_ready;
    logic       w_load;

    assign w_opcode = i_if_ir[6:0];
    assign w_funct3 = i_if_ir[14:12];
    assign w_funct7 = i_if_ir[31:25];
    assign w_rs1    = i_if_ir[19:15];
    assign w_rs2    = i_if_ir[24:20];
    assign w_ex_rd  = r_ir[11:7];

    // Instruction decode of the incoming IF instruction into the control bundle.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_dec = '0;
        unique case (w_opcode)
            OPC_LUI: begin
                w_dec.alu_fun   = 5'b01001;
                w_dec.alu_srca  = 1'b1;
                w_dec.rf_wr_sel = 2'b11;
                w_dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.alu_srca  = 1'b1;
                w_dec.alu_srcb  = 2'b11;
                w_dec.rf_wr_sel = 2'b11;
                w_dec.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                w_dec.reg_write = 1'b1;
                w_dec.jump      = 1'b1;
            end
            OPC_STORE: begin
                w_dec.alu_srcb  = 2'b10;
                w_dec.mem_write = 1'b1;
            end
            OPC_LOAD: begin
                w_dec.alu_srcb  = 2'b01;
                w_dec.rf_wr_sel = 2'b10;
                w_dec.mem_read2 = 1'b1;
                w_dec.reg_write = 1'b1;
            end
            OPC_OP_IMM: begin
                w_dec.alu_srcb  = 2'b01;
                w_dec.rf_wr_sel = 2'b11;
                w_dec.reg_write = 1'b1;
                // Only the shift-right immediates use IR[30] to pick SRA vs SRL.
                if (w_funct3 == 3'b101) begin
                    w_dec.alu_fun = {1'b0, i_if_ir[30], w_funct3};
                end else begin
                    w_dec.alu_fun = {2'b00, w_funct3};
                end
            end
            OPC_OP: begin
                if (w_funct7 == 7'b0000001) begin
                    if (EN_MUL != 0) begin
                        w_dec.alu_fun   = {2'b10, w_funct3};
                        w_dec.rf_wr_sel = 2'b11;
                        w_dec.reg_write = 1'b1;
                    end else begin
                        w_dec.illegal = 1'b1;
                    end
                end else begin
                    w_dec.alu_fun   = {1'b0, i_if_ir[30], w_funct3};
                    w_dec.rf_wr_sel = 2'b11;
                    w_dec.reg_write = 1'b1;
                end
            end
            OPC_BRANCH: begin
                w_dec.branch = 1'b1;
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the load in EX writes a register the IF instruction reads.
    always_comb begin
        w_use_rs1 = !((w_opcode == OPC_LUI) || (w_opcode == OPC_AUIPC) || (w_opcode == OPC_JAL));
        w_use_rs2 = (w_opcode == OPC_OP) || (w_opcode == OPC_STORE) || (w_opcode == OPC_BRANCH);
        w_hazard  = r_valid && r_ctrl.mem_read2 && (w_ex_rd != 5'd0) && i_if_valid &&
                    ((w_use_rs1 && (w_rs1 == w_ex_rd)) || (w_use_rs2 && (w_rs2 == w_ex_rd)));
    end

    // The stage accepts a new instruction only when running, unstalled and hazard-free;
    // a flush on the same edge still wins over the load.
    assign w_ready = !i_ex_stall && !w_hazard && (r_state == ST_RUN);
    assign w_load  = w_ready && !i_flush;

    // Next-state logic: an issued illegal slot parks the stage until a flush.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = ST_RUN;
        end else if ((TRAP_HOLD != 0) && w_load && i_if_valid && w_dec.illegal) begin
            w_state_nxt = ST_HALT;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always assigned with <= so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ID/EX pipeline register and issue counter, in flush > stall > bubble > load priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_ir    <= '0;
            r_ctrl  <= '0;
            r_cnt   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_ex_stall) begin
            r_valid <= r_valid;
        end else if (!w_load) begin
            // Halted or load-use: push a bubble with all side effects cleared.
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            r_valid <= i_if_valid;
            r_pc    <= i_if_pc;
            r_ir    <= i_if_ir;
            r_ctrl  <= i_if_valid ? w_dec : '0;
            if (i_if_valid) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_id_ready        = w_ready;
    assign o_id_ex_valid     = r_valid;
    assign o_id_ex_pc        = r_pc;
    assign o_id_ex_ir        = r_ir;
    assign o_id_ex_alu_fun   = r_ctrl.alu_fun[AFW-1:0];
    assign o_id_ex_alu_srca  = r_ctrl.alu_srca;
    assign o_id_ex_alu_srcb  = r_ctrl.alu_srcb;
    assign o_id_ex_rf_wr_sel = r_ctrl.rf_wr_sel;
    assign o_id_ex_reg_write = r_ctrl.reg_write;
    assign o_id_ex_mem_write = r_ctrl.mem_write;
    assign o_id_ex_mem_read2 = r_ctrl.mem_read2;
    assign o_id_ex_branch    = r_ctrl.branch;
    assign o_id_ex_jump      = r_ctrl.jump;
    assign o_id_ex_illegal   = r_ctrl.illegal;
    assign o_halted          = (r_state == ST_HALT);
    assign o_issue_cnt       = r_cnt;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed bench for id_decode_stage.
// Instance u_a decodes RV32M and halts on illegal instructions; instance u_b has
// no RV32M, keeps issuing illegal slots and uses a 2-bit issue counter. Both see
// the same stimulus.
module tb_id_decode_stage;

    // Expected control words, packed as
    // {alu_fun[4:0], srca, srcb[1:0], wr_sel[1:0], reg_write, mem_write, mem_read2, branch, jump, illegal}
    localparam logic [15:0] C_OPIMM0 = {5'd0,  1'b0, 2'b01, 2'b11, 6'b100000};
    localparam logic [15:0] C_SLTI   = {5'd2,  1'b0, 2'b01, 2'b11, 6'b100000};
    localparam logic [15:0] C_SRAI   = {5'd13, 1'b0, 2'b01, 2'b11, 6'b100000};
    localparam logic [15:0] C_SRA    = {5'd13, 1'b0, 2'b00, 2'b11, 6'b100000};
    localparam logic [15:0] C_ADD    = {5'd0,  1'b0, 2'b00, 2'b11, 6'b100000};
    localparam logic [15:0] C_MUL    = {5'd16, 1'b0, 2'b00, 2'b11, 6'b100000};
    localparam logic [15:0] C_STORE  = {5'd0,  1'b0, 2'b10, 2'b00, 6'b010000};
    localparam logic [15:0] C_BRANCH = {5'd0,  1'b0, 2'b00, 2'b00, 6'b000100};
    localparam logic [15:0] C_JUMP   = {5'd0,  1'b0, 2'b00, 2'b00, 6'b100010};
    localparam logic [15:0] C_LUI    = {5'd9,  1'b1, 2'b00, 2'b11, 6'b100000};
    localparam logic [15:0] C_AUIPC  = {5'd0,  1'b1, 2'b11, 2'b11, 6'b100000};
    localparam logic [15:0] C_LOAD   = {5'd0,  1'b0, 2'b01, 2'b10, 6'b101000};
    localparam logic [15:0] C_ILL    = {5'd0,  1'b0, 2'b00, 2'b00, 6'b000001};
    localparam logic [15:0] C_NONE   = 16'h0000;

    localparam logic [31:0] I_ADDI   = 32'h00500093;
    localparam logic [31:0] I_LW_X5  = 32'h0000A283;
    localparam logic [31:0] I_ADD_X5 = 32'h00528333;
    localparam logic [31:0] I_LW_X0  = 32'h0000A003;
    localparam logic [31:0] I_ADD_X0 = 32'h00000333;
    localparam logic [31:0] I_MUL    = 32'h022081B3;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        ex_stall;
    logic        flush;

    logic        a_ready, a_valid, a_srca, a_rw, a_mw, a_mr, a_br, a_jp, a_il, a_halted;
    logic [31:0] a_pc, a_ir;
    logic [4:0]  a_alu;
    logic [1:0]  a_srcb, a_wsel;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid, b_srca, b_rw, b_mw, b_mr, b_br, b_jp, b_il, b_halted;
    logic [31:0] b_pc, b_ir;
    logic [3:0]  b_alu;
    logic [1:0]  b_srcb, b_wsel;
    logic [1:0]  b_cnt;

    logic [15:0] a_ctrl;
    logic [15:0] b_ctrl;
    assign a_ctrl = {a_alu, a_srca, a_srcb, a_wsel, a_rw, a_mw, a_mr, a_br, a_jp, a_il};
    assign b_ctrl = {1'b0, b_alu, b_srca, b_srcb, b_wsel, b_rw, b_mw, b_mr, b_br, b_jp, b_il};

    int          n_total;
    int          n_bad;
    int          exp_a;
    int          exp_b;
    logic [31:0] pc_nxt;
    logic [31:0] pc_hold;

    id_decode_stage #(.XLEN(32), .EN_MUL(1), .TRAP_HOLD(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n),
        .i_if_valid(if_valid), .i_if_ir(if_ir), .i_if_pc(if_pc),
        .i_ex_stall(ex_stall), .i_flush(flush),
        .o_id_ready(a_ready), .o_id_ex_valid(a_valid), .o_id_ex_pc(a_pc), .o_id_ex_ir(a_ir),
        .o_id_ex_alu_fun(a_alu), .o_id_ex_alu_srca(a_srca), .o_id_ex_alu_srcb(a_srcb),
        .o_id_ex_rf_wr_sel(a_wsel), .o_id_ex_reg_write(a_rw), .o_id_ex_mem_write(a_mw),
        .o_id_ex_mem_read2(a_mr), .o_id_ex_branch(a_br), .o_id_ex_jump(a_jp),
        .o_id_ex_illegal(a_il), .o_halted(a_halted), .o_issue_cnt(a_cnt)
    );

    id_decode_stage #(.XLEN(32), .EN_MUL(0), .TRAP_HOLD(0), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n),
        .i_if_valid(if_valid), .i_if_ir(if_ir), .i_if_pc(if_pc),
        .i_ex_stall(ex_stall), .i_flush(flush),
        .o_id_ready(b_ready), .o_id_ex_valid(b_valid), .o_id_ex_pc(b_pc), .o_id_ex_ir(b_ir),
        .o_id_ex_alu_fun(b_alu), .o_id_ex_alu_srca(b_srca), .o_id_ex_alu_srcb(b_srcb),
        .o_id_ex_rf_wr_sel(b_wsel), .o_id_ex_reg_write(b_rw), .o_id_ex_mem_write(b_mw),
        .o_id_ex_mem_read2(b_mr), .o_id_ex_branch(b_br), .o_id_ex_jump(b_jp),
        .o_id_ex_illegal(b_il), .o_halted(b_halted), .o_issue_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir);
        if_valid = 1'b1;
        if_ir    = ir;
        if_pc    = pc_nxt;
    endtask

    // Issue one instruction with no hazard/halt pending; both instances must
    // register it with the same control word.
    task automatic issue_vec(input string tag, input logic [31:0] ir, input logic [15:0] exp);
        drive(ir);
        tick();
        exp_a++;
        exp_b++;
        check({tag, ".ctrl_a"}, a_ctrl, exp);
        check({tag, ".ctrl_b"}, b_ctrl, exp);
        check({tag, ".valid"}, a_valid, 1'b1);
        check({tag, ".pc"}, a_pc, pc_nxt);
        check({tag, ".ir"}, a_ir, ir);
        check({tag, ".cnt_a"}, a_cnt, exp_a);
        check({tag, ".cnt_b"}, b_cnt, exp_b % 4);
        pc_nxt = pc_nxt + 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_total  = 0;
        n_bad    = 0;
        exp_a    = 0;
        exp_b    = 0;
        pc_nxt   = 32'h0000_0100;
        pc_hold  = '0;
        rst_n    = 1'b0;
        if_valid = 1'b0;
        if_ir    = '0;
        if_pc    = '0;
        ex_stall = 1'b0;
        flush    = 1'b0;

        // Power-on reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst.valid", a_valid, 1'b0);
        check("rst.ctrl", a_ctrl, C_NONE);
        check("rst.halted", a_halted, 1'b0);
        check("rst.cnt", a_cnt, 16'd0);
        check("rst.ready", a_ready, 1'b1);
        #2 rst_n = 1'b1;

        // Decode table across all opcode classes.
        issue_vec("addi", I_ADDI, C_OPIMM0);
        issue_vec("addi_neg", 32'hFFF00093, C_OPIMM0);
        issue_vec("slti", 32'hFFF12093, C_SLTI);
        issue_vec("srai", 32'h4020D193, C_SRAI);
        issue_vec("sra", 32'h4020D1B3, C_SRA);
        issue_vec("sw", 32'h0020A023, C_STORE);
        issue_vec("beq", 32'h00208463, C_BRANCH);
        issue_vec("jal", 32'h008000EF, C_JUMP);
        issue_vec("jalr", 32'h000100E7, C_JUMP);
        issue_vec("lui", 32'h123450B7, C_LUI);
        issue_vec("auipc", 32'h00001097, C_AUIPC);

        // MUL: legal with RV32M, illegal (but still issued, no halt) without it.
        drive(I_MUL);
        tick();
        exp_a++;
        exp_b++;
        pc_nxt = pc_nxt + 32'd4;
        check("mul.ctrl_a", a_ctrl, C_MUL);
        check("mul.ctrl_b", b_ctrl, C_ILL);
        check("mul.valid_b", b_valid, 1'b1);
        check("mul.halted_b", b_halted, 1'b0);
        check("mul.cnt_b", b_cnt, exp_b % 4);

        // IF_VALID low: bubble with controls forced to zero, no count.
        if_valid = 1'b0;
        if_ir    = I_ADDI;
        tick();
        check("ifinv.valid", a_valid, 1'b0);
        check("ifinv.ctrl", a_ctrl, C_NONE);
        check("ifinv.cnt", a_cnt, exp_a);

        // Load-use on x5: one-cycle stall and one bubble, then the add issues.
        issue_vec("lw_x5", I_LW_X5, C_LOAD);
        drive(I_ADD_X5);
        #1;
        check("lu.ready_a", a_ready, 1'b0);
        check("lu.ready_b", b_ready, 1'b0);
        tick();
        check("lu.bubble_valid", a_valid, 1'b0);
        check("lu.bubble_ctrl", a_ctrl, C_NONE);
        check("lu.bubble_cnt", a_cnt, exp_a);
        check("lu.ready_after", a_ready, 1'b1);
        issue_vec("lu.add", I_ADD_X5, C_ADD);

        // Same pattern with rd=x0: no hazard.
        issue_vec("lw_x0", I_LW_X0, C_LOAD);
        drive(I_ADD_X0);
        #1;
        check("lu0.ready", a_ready, 1'b1);
        issue_vec("lu0.add", I_ADD_X0, C_ADD);

        // FLUSH + EX_STALL + hazard together: flush wins, counter unchanged.
        issue_vec("lw_x5b", I_LW_X5, C_LOAD);
        drive(I_ADD_X5);
        ex_stall = 1'b1;
        flush    = 1'b1;
        #1;
        check("fsh.ready", a_ready, 1'b0);
        tick();
        check("fsh.valid_a", a_valid, 1'b0);
        check("fsh.valid_b", b_valid, 1'b0);
        check("fsh.ctrl", a_ctrl, C_NONE);
        check("fsh.cnt", a_cnt, exp_a);
        ex_stall = 1'b0;
        flush    = 1'b0;
        #1;
        check("fsh.ready_after", a_ready, 1'b1);
        pc_hold = pc_nxt;
        issue_vec("fsh.add", I_ADD_X5, C_ADD);

        // EX_STALL alone for 4 cycles: slot held bit-exact while IF changes.
        ex_stall = 1'b1;
        drive(I_ADDI);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stall.valid", a_valid, 1'b1);
            check("stall.ir", a_ir, I_ADD_X5);
            check("stall.pc", a_pc, pc_hold);
            check("stall.ctrl", a_ctrl, C_ADD);
            check("stall.cnt", a_cnt, exp_a);
            check("stall.ready", a_ready, 1'b0);
        end
        ex_stall = 1'b0;

        // Illegal opcode 0: u_a issues it once then halts until FLUSH; u_b continues.
        drive(32'h0000_0000);
        tick();
        exp_a++;
        exp_b++;
        pc_nxt = pc_nxt + 32'd4;
        check("ill.valid", a_valid, 1'b1);
        check("ill.ctrl_a", a_ctrl, C_ILL);
        check("ill.ctrl_b", b_ctrl, C_ILL);
        check("ill.cnt", a_cnt, exp_a);
        check("ill.halted", a_halted, 1'b1);
        check("ill.ready", a_ready, 1'b0);
        check("ill.halted_b", b_halted, 1'b0);
        drive(I_ADDI);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_b++;
            check("halt.valid", a_valid, 1'b0);
            check("halt.ctrl", a_ctrl, C_NONE);
            check("halt.halted", a_halted, 1'b1);
            check("halt.ready", a_ready, 1'b0);
            check("halt.cnt", a_cnt, exp_a);
            check("halt.valid_b", b_valid, 1'b1);
            check("halt.cnt_b", b_cnt, exp_b % 4);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("unhalt.halted", a_halted, 1'b0);
        check("unhalt.valid", a_valid, 1'b0);
        check("unhalt.ready", a_ready, 1'b1);
        pc_nxt = pc_nxt + 32'd8;
        issue_vec("unhalt.addi", I_ADDI, C_OPIMM0);

        // Asynchronous reset mid-cycle with IF_VALID held high.
        #3;
        rst_n = 1'b0;
        #1;
        check("arst.valid", a_valid, 1'b0);
        check("arst.ctrl", a_ctrl, C_NONE);
        check("arst.ir", a_ir, 32'd0);
        check("arst.cnt", a_cnt, 16'd0);
        check("arst.cnt_b", b_cnt, 2'd0);
        check("arst.halted", a_halted, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("arst.hold_valid", a_valid, 1'b0);
        end
        #2 rst_n = 1'b1;
        exp_a = 0;
        exp_b = 0;
        issue_vec("post_rst", I_ADDI, C_OPIMM0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage (ID→EX) for the pipelined MCU.
- Decodes the fetched instruction into the EX-stage control bundle and registers it with PC/IR and a valid bit.
- Handles downstream stall, branch flush, load-use bubble insertion and an illegal-instruction halt.
- Optional M-extension decode; issue counter for debug.

Parameters:
XLEN, 32, PC width.
EN_MUL, 0, 1 = decode RV32M (funct7=0000001 R-type); ALU_FUN widens to 5 bits.
TRAP_HOLD, 1, 1 = illegal instruction halts the stage until FLUSH; 0 = issue it marked ILLEGAL and continue.
CNT_W, 16, width of the issue counter.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
IF_VALID  in  1  IF_IR/IF_PC valid.
IF_IR  in  32  fetched instruction.
IF_PC  in  XLEN  PC of IF_IR.
EX_STALL  in  1  EX cannot accept; hold the stage.
FLUSH  in  1  taken branch/jump; kill the stage contents.
ID_READY  out  1  combinational; IF may advance this cycle.
ID_EX_VALID  out  1  registered slot valid.
ID_EX_PC  out  XLEN  registered PC.
ID_EX_IR  out  32  registered IR.
ID_EX_ALU_FUN  out  AFW  AFW = EN_MUL ? 5 : 4.
ID_EX_ALU_SRCA  out  1
ID_EX_ALU_SRCB  out  2
ID_EX_RF_WR_SEL  out  2
ID_EX_REG_WRITE  out  1
ID_EX_MEM_WRITE  out  1
ID_EX_MEM_READ2  out  1
ID_EX_BRANCH  out  1  opcode 1100011.
ID_EX_JUMP  out  1  JAL/JALR.
ID_EX_ILLEGAL  out  1  unrecognised opcode/funct.
HALTED  out  1  FSM in HALT.
ISSUE_CNT  out  CNT_W  count of valid slots issued.

Behaviour:
- Reset (async, RST_N=0): all registered outputs 0; FSM=RUN; ISSUE_CNT=0.
- Decode table:
  - AUIPC: SRCA=1, SRCB=11, WR_SEL=11, REG_WRITE=1.
  - JAL/JALR: REG_WRITE=1, WR_SEL=00, JUMP=1.
  - Store: SRCB=10, MEM_WRITE=1.
  - Load: SRCB=01, WR_SEL=10, MEM_READ2=1, REG_WRITE=1.
  - LUI: ALU_FUN=1001, SRCA=1, WR_SEL=11, REG_WRITE=1.
  - OP-IMM: SRCB=01, WR_SEL=11, REG_WRITE=1. ALU_FUN={0,f3}, except f3=101 gives {IR[30],101}.
  - OP: WR_SEL=11, REG_WRITE=1, ALU_FUN={IR[30],f3}.
  - Branch: BRANCH=1, SRCB=00, all writes 0.
  - Any other opcode: ILLEGAL=1, all side-effect controls 0.
  - Unlisted fields default to 0.
  - EN_MUL=1: base ALU_FUN is zero-extended to 5 bits; funct7=0000001 OP gives ALU_FUN={1,0,f3}.
  - EN_MUL=0: funct7=0000001 OP decodes as ILLEGAL.
- Load-use hazard (combinational), all of the following true:
  - ID_EX_VALID and ID_EX_MEM_READ2 set;
  - rd=ID_EX_IR[11:7] is nonzero;
  - IF_VALID set;
  - either rs1 is used and IF_IR[19:15]==rd, or rs2 is used and IF_IR[24:20]==rd.
  - rs1 is used by all opcodes except LUI/AUIPC/JAL. rs2 is used by OP, store and branch only.
- ID_READY = !EX_STALL & !hazard & (FSM==RUN).
- Register update priority, evaluated each edge:
  1. FLUSH: VALID←0, controls←0, FSM←RUN. FLUSH overrides EX_STALL, hazard and HALT.
  2. EX_STALL: hold every register.
  3. FSM==HALT: VALID←0 (bubble).
  4. hazard: insert bubble (VALID←0, controls←0). IF holds. Lasts exactly 1 cycle.
  5. Otherwise: VALID←IF_VALID; PC/IR/controls←decode(IF_IR). When IF_VALID=0, controls are forced to 0.
- Bubble invariant: VALID=0 implies REG_WRITE, MEM_WRITE, MEM_READ2, BRANCH, JUMP and ILLEGAL are all 0.
- Latency: 1 cycle IF→ID_EX.
- FSM (RUN, HALT):
  - RUN→HALT when TRAP_HOLD=1 and an ILLEGAL slot is issued (branch 5 with decode ILLEGAL). The illegal slot is issued with VALID=1, ILLEGAL=1; HALTED=1 from the next cycle.
  - HALT→RUN only on FLUSH.
  - TRAP_HOLD=0: FSM stays in RUN.
- ISSUE_CNT: +1 on each edge where branch 5 loads VALID=1. Wraps modulo 2^CNT_W. No increment on flush, stall, bubble or HALT.

Test Plan:
- Reset mid-stream: RST_N low asynchronously for 3 cycles with IF_VALID=1 → all outputs 0 immediately (not at the next edge); HALTED=0; ISSUE_CNT=0.
- IF_IR=0x00500093 (addi x1,x0,5) → next cycle VALID=1, ALU_FUN=0000, SRCB=01, WR_SEL=11, REG_WRITE=1; ISSUE_CNT=1.
- 0x4020D1B3 (sra) → ALU_FUN=1101. 0x022081B3 (mul): EN_MUL=1 → ALU_FUN=10000; EN_MUL=0 → ILLEGAL=1, REG_WRITE=0.
- Load-use: 0x0000A283 (lw x5) then 0x00528333 (add x6,x5,x5) → ID_READY=0 for one cycle and one bubble, then add issues. Same test with rd=x0 → no bubble.
- FLUSH, EX_STALL and hazard asserted in the same cycle → VALID=0 next edge; counter unchanged. EX_STALL alone for 4 cycles → outputs held bit-exact.
- IF_IR=0x00000000, TRAP_HOLD=1 → illegal slot issued once, then HALTED=1 and ID_READY=0 until FLUSH, then RUN. CNT_W=2: 5 issues → ISSUE_CNT=1 (wrap).
